// File: rtl/delay_pkg.sv
// Shared constants and types for the delay-line scheduler.
package delay_pkg;

    localparam int unsigned TS_W  = 8;
    localparam int unsigned DEPTH = 8;

    localparam logic MODE_TRANSPORT = 1'b0;
    localparam logic MODE_INERTIAL  = 1'b1;

    typedef enum logic {IDLE, ACTIVE} state_e;

endpackage

// File: rtl/delay_event_fifo.sv
// Timestamp queue: push at tail, pop at head, and tail-drop for inertial pulse cancellation.
module delay_event_fifo
    import delay_pkg::*;
#(
    parameter int unsigned TS_W  = delay_pkg::TS_W,
    parameter int unsigned DEPTH = delay_pkg::DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_drop,
    input  logic [TS_W-1:0]            i_ts,
    output logic [TS_W-1:0]            o_head,
    output logic [TS_W-1:0]            o_tail,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic [$clog2(DEPTH):0]     o_count_next
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [TS_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]   r_rd;
    logic [PW-1:0]   r_wr;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_next;
    logic [PW-1:0]   w_tail_idx;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr] <= i_ts;
        end
    end

    // Push and drop are mutually exclusive; pop may coincide with either.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wr <= r_wr + PW'(1);
            end else if (i_drop) begin
                r_wr <= r_wr - PW'(1);
            end
            if (i_pop) begin
                r_rd <= r_rd + PW'(1);
            end
            r_count <= w_count_next;
        end
    end

    always_comb begin
        w_count_next = r_count;
        if (i_push) w_count_next = w_count_next + CW'(1);
        if (i_pop)  w_count_next = w_count_next - CW'(1);
        if (i_drop) w_count_next = w_count_next - CW'(1);
    end

    assign w_tail_idx   = r_wr - PW'(1);
    assign o_head       = r_mem[r_rd];
    assign o_tail       = r_mem[w_tail_idx];
    assign o_full       = (r_count == CW'(DEPTH));
    assign o_empty      = (r_count == '0);
    assign o_count      = r_count;
    assign o_count_next = w_count_next;

endmodule

// File: rtl/delay_line_scheduler.sv
// Delays each transition of a by a latched number of cycles, in transport or inertial mode.
module delay_line_scheduler
    import delay_pkg::*;
#(
    parameter int unsigned TS_W  = delay_pkg::TS_W,
    parameter int unsigned DEPTH = delay_pkg::DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   mode,
    input  logic [TS_W-1:0]        dly,
    input  logic                   a,
    output logic                   y,
    output logic                   busy,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] pending
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    state_e          r_state;
    state_e          w_state_next;
    logic            r_a_q;
    logic            r_y;
    logic            r_overflow;
    logic [TS_W-1:0] r_cnt;
    logic [TS_W-1:0] r_dly_l;

    logic            w_trans;
    logic            w_push;
    logic            w_pop;
    logic            w_cancel;
    logic            w_drop_evt;
    logic [TS_W-1:0] w_head;
    logic [TS_W-1:0] w_tail;
    logic            w_full;
    logic            w_empty;
    logic [CW-1:0]   w_count;
    logic [CW-1:0]   w_count_next;

    delay_event_fifo #(
        .TS_W  (TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_push       (w_push),
        .i_pop        (w_pop),
        .i_drop       (w_cancel),
        .i_ts         (r_cnt),
        .o_head       (w_head),
        .o_tail       (w_tail),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_count      (w_count),
        .o_count_next (w_count_next)
    );

    assign w_trans = en && (a != r_a_q);
    assign w_pop   = !w_empty && ((r_cnt - w_head) == r_dly_l);

    // A lone entry that is popping this cycle cannot be cancelled; the new edge is pushed instead.
    assign w_cancel = (mode == MODE_INERTIAL) && w_trans && !w_empty
                      && ((r_cnt - w_tail) < r_dly_l)
                      && !(w_pop && (w_count == CW'(1)));

    assign w_push     = w_trans && !w_cancel && (!w_full || w_pop);
    assign w_drop_evt = w_trans && !w_cancel && w_full && !w_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_q      <= 1'b0;
            r_cnt      <= '0;
            r_y        <= 1'b0;
            r_overflow <= 1'b0;
            r_dly_l    <= TS_W'(1);
        end else begin
            r_a_q <= a;
            r_cnt <= r_cnt + TS_W'(1);
            if (w_pop) begin
                r_y <= ~r_y;
            end
            if (w_drop_evt) begin
                r_overflow <= 1'b1;
            end
            if (r_state == IDLE) begin
                r_dly_l <= (dly == '0) ? TS_W'(1) : dly;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (w_push) w_state_next = ACTIVE;
            ACTIVE:  if (w_count_next == '0) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        busy     = (r_state == ACTIVE);
        y        = r_y;
        overflow = r_overflow;
        pending  = w_count;
    end

endmodule

// File: tb/tb_delay_line_scheduler.sv
// Directed-vector bench for delay_line_scheduler with default TS_W=8, DEPTH=8.
module tb_delay_line_scheduler;

    logic       clk;
    logic       rst;
    logic       en;
    logic       mode;
    logic [7:0] dly;
    logic       a;
    logic       y;
    logic       busy;
    logic       overflow;
    logic [3:0] pending;

    int errs;
    int checks;

    delay_line_scheduler dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .dly      (dly),
        .a        (a),
        .y        (y),
        .busy     (busy),
        .overflow (overflow),
        .pending  (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // After this returns, the next rising edge is the one where cnt=0.
    task automatic do_reset(input logic [7:0] d, input logic m);
        rst  = 1'b1;
        en   = 1'b0;
        a    = 1'b0;
        mode = m;
        dly  = d;
        tick();
        tick();
        rst = 1'b0;
        en  = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a   = 1'b1;
        en  = 1'b1;
        #3;
        checks++;
        if ({y, busy, overflow, pending} !== 7'b0) begin
            errs++;
            $display("FAIL reset_hold: got y=%b busy=%b ovf=%b pend=%0d want all 0",
                     y, busy, overflow, pending);
        end
        do_reset(8'd4, 1'b0);
        tick();
        checks++;
        if ({y, busy, overflow, pending} !== 7'b0) begin
            errs++;
            $display("FAIL reset_idle: got y=%b busy=%b ovf=%b pend=%0d want all 0",
                     y, busy, overflow, pending);
        end
    endtask

    task automatic test_transport();
        bit a_seq [12] = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0};
        bit y_exp [12] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0};
        int p_exp [12] = '{0, 0, 0, 1, 1, 2, 2, 1, 1, 0, 0, 0};
        do_reset(8'd4, 1'b0);
        for (int k = 0; k < 12; k++) begin
            a = a_seq[k];
            tick();
            checks++;
            if (y !== y_exp[k] || pending !== 4'(p_exp[k])) begin
                errs++;
                $display("FAIL transport edge %0d: got y=%b pend=%0d want y=%b pend=%0d",
                         k, y, pending, y_exp[k], p_exp[k]);
            end
        end
    endtask

    task automatic test_inertial();
        bit a_seq [12] = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0};
        bit b_exp [12] = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0};
        int p_exp [12] = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0};
        do_reset(8'd4, 1'b1);
        for (int k = 0; k < 12; k++) begin
            a = a_seq[k];
            tick();
            checks++;
            if (y !== 1'b0 || busy !== b_exp[k] || pending !== 4'(p_exp[k])) begin
                errs++;
                $display("FAIL inertial edge %0d: got y=%b busy=%b pend=%0d want y=0 busy=%b pend=%0d",
                         k, y, busy, pending, b_exp[k], p_exp[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit a_seq [14] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0};
        bit y_exp [14] = '{0, 0, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0};
        int p_exp [14] = '{1, 2, 3, 3, 3, 3, 3, 3, 3, 3, 2, 1, 0, 0};
        do_reset(8'd3, 1'b0);
        for (int k = 0; k < 14; k++) begin
            a = a_seq[k];
            tick();
            checks++;
            if (y !== y_exp[k] || pending !== 4'(p_exp[k])) begin
                errs++;
                $display("FAIL b2b edge %0d: got y=%b pend=%0d want y=%b pend=%0d",
                         k, y, pending, y_exp[k], p_exp[k]);
            end
        end
        checks++;
        if (overflow !== 1'b0) begin
            errs++;
            $display("FAIL b2b_overflow: got %b want 0", overflow);
        end
    endtask

    task automatic test_overflow();
        do_reset(8'd20, 1'b0);
        for (int k = 0; k < 8; k++) begin
            a = ~a;
            tick();
        end
        checks++;
        if (pending !== 4'd8 || overflow !== 1'b0) begin
            errs++;
            $display("FAIL ovf_full: got pend=%0d ovf=%b want pend=8 ovf=0", pending, overflow);
        end
        a = ~a;
        tick();
        checks++;
        if (pending !== 4'd8 || overflow !== 1'b1) begin
            errs++;
            $display("FAIL ovf_drop: got pend=%0d ovf=%b want pend=8 ovf=1", pending, overflow);
        end
        repeat (3) tick();
        checks++;
        if (overflow !== 1'b1 || y !== 1'b0) begin
            errs++;
            $display("FAIL ovf_sticky: got ovf=%b y=%b want ovf=1 y=0", overflow, y);
        end
    endtask

    task automatic test_wrap();
        do_reset(8'd255, 1'b0);
        repeat (250) tick();
        a = 1'b1;
        tick();
        checks++;
        if (pending !== 4'd1 || busy !== 1'b1) begin
            errs++;
            $display("FAIL wrap_stamp: got pend=%0d busy=%b want pend=1 busy=1", pending, busy);
        end
        repeat (10) tick();
        dly = 8'd5;
        repeat (244) tick();
        checks++;
        if (y !== 1'b0 || busy !== 1'b1) begin
            errs++;
            $display("FAIL wrap_early: got y=%b busy=%b want y=0 busy=1", y, busy);
        end
        tick();
        checks++;
        if (y !== 1'b1 || pending !== 4'd0 || busy !== 1'b0) begin
            errs++;
            $display("FAIL wrap_toggle: got y=%b pend=%0d busy=%b want y=1 pend=0 busy=0",
                     y, pending, busy);
        end
        tick();
        a = 1'b0;
        tick();
        repeat (4) tick();
        checks++;
        if (y !== 1'b1) begin
            errs++;
            $display("FAIL relatch_early: got y=%b want 1", y);
        end
        tick();
        checks++;
        if (y !== 1'b0 || pending !== 4'd0) begin
            errs++;
            $display("FAIL relatch_toggle: got y=%b pend=%0d want y=0 pend=0", y, pending);
        end
    endtask

    task automatic test_reset_mid();
        bit bad;
        do_reset(8'd4, 1'b0);
        a = 1'b1;
        repeat (5) tick();
        a = 1'b0;
        tick();
        a = 1'b1;
        tick();
        checks++;
        if (pending !== 4'd2 || y !== 1'b1) begin
            errs++;
            $display("FAIL rstmid_pre: got pend=%0d y=%b want pend=2 y=1", pending, y);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (y !== 1'b0 || pending !== 4'd0 || busy !== 1'b0) begin
            errs++;
            $display("FAIL rstmid_async: got y=%b pend=%0d busy=%b want all 0", y, pending, busy);
        end
        a = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        bad = 1'b0;
        repeat (12) begin
            tick();
            if (y !== 1'b0 || pending !== 4'd0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errs++;
            $display("FAIL rstmid_quiet: got late activity y=%b pend=%0d want none", y, pending);
        end
        a = 1'b1;
        tick();
        checks++;
        if (pending !== 4'd1 || busy !== 1'b1) begin
            errs++;
            $display("FAIL rstmid_first: got pend=%0d busy=%b want pend=1 busy=1", pending, busy);
        end
    endtask

    task automatic test_en_gate();
        do_reset(8'd4, 1'b0);
        a = 1'b1;
        tick();
        en = 1'b0;
        a  = 1'b0;
        tick();
        a = 1'b1;
        tick();
        a = 1'b0;
        tick();
        checks++;
        if (pending !== 4'd1) begin
            errs++;
            $display("FAIL en_gate: got pend=%0d want 1", pending);
        end
        tick();
        checks++;
        if (y !== 1'b1 || pending !== 4'd0) begin
            errs++;
            $display("FAIL en_drain: got y=%b pend=%0d want y=1 pend=0", y, pending);
        end
        en = 1'b1;
        tick();
        checks++;
        if (pending !== 4'd0) begin
            errs++;
            $display("FAIL en_aq_track: got pend=%0d want 0", pending);
        end
    endtask

    task automatic test_min_delay();
        do_reset(8'd0, 1'b0);
        tick();
        a = 1'b1;
        tick();
        checks++;
        if (y !== 1'b0 || pending !== 4'd1) begin
            errs++;
            $display("FAIL dly0_stamp: got y=%b pend=%0d want y=0 pend=1", y, pending);
        end
        tick();
        checks++;
        if (y !== 1'b1 || pending !== 4'd0) begin
            errs++;
            $display("FAIL dly0_toggle: got y=%b pend=%0d want y=1 pend=0", y, pending);
        end
    endtask

    initial begin
        errs   = 0;
        checks = 0;
        rst    = 1'b1;
        en     = 1'b0;
        mode   = 1'b0;
        dly    = 8'd1;
        a      = 1'b0;
        test_reset();
        test_transport();
        test_inertial();
        test_back_to_back();
        test_overflow();
        test_wrap();
        test_reset_mid();
        test_en_gate();
        test_min_delay();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/delay_line_scheduler.md
DELAY_LINE_SCHEDULER -- requirements
Module: delay_line_scheduler

Interface
REQ-001 Parameter TS_W, default 8: timestamp and delay width in bits.
REQ-002 Parameter DEPTH, default 8: pending-event queue depth, power of two.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port en, input, 1: event capture enable.
REQ-006 Port mode, input, 1: 0 = transport delay, 1 = inertial delay.
REQ-007 Port dly, input, TS_W: requested delay in clk cycles.
REQ-008 Port a, input, 1: signal to be delayed.
REQ-009 Port y, output, 1: delayed copy of a.
REQ-010 Port busy, output, 1: high while any event is pending.
REQ-011 Port overflow, output, 1: sticky flag for a dropped event.
REQ-012 Port pending, output, $clog2(DEPTH)+1: count of queued events.

Function
REQ-013 The block SHALL register a into a_q every cycle, regardless of en.
REQ-014 The block SHALL treat a transition as en=1 and a!=a_q at a clk edge, stamped with the free-running TS_W counter value cnt at that edge.
REQ-015 The block SHALL store each accepted transition timestamp in a FIFO of DEPTH entries.
REQ-016 The block SHALL pop the head entry and toggle y at the edge where (cnt - head_ts) mod 2^TS_W equals dly_l.
REQ-017 Latency SHALL be exactly dly_l cycles from the stamping edge to the toggling edge of y.
REQ-018 The block SHALL latch dly_l = max(dly,1) only in state IDLE; changes to dly while in ACTIVE SHALL be ignored until the block returns to IDLE.
REQ-019 The FSM SHALL have two states: IDLE (queue empty) and ACTIVE (queue non-empty).
REQ-020 IDLE SHALL go to ACTIVE on push; ACTIVE SHALL go to IDLE when a pop empties the queue with no simultaneous push.
REQ-021 busy SHALL equal (state==ACTIVE); pending SHALL equal the queue occupancy.
REQ-022 A push and a pop in the same cycle SHALL both take effect, leaving occupancy unchanged.
REQ-023 In transport mode, every accepted transition SHALL be pushed.
REQ-024 In inertial mode, a transition with a non-empty queue and (cnt - tail_ts) mod 2^TS_W < dly_l SHALL remove the tail entry instead of pushing, which cancels the short pulse.
REQ-025 If the inertial cancel targets the entry being popped in the same cycle, the pop SHALL win and the new transition SHALL be pushed.
REQ-026 A transition arriving with the queue full and no pop in the same cycle SHALL be dropped and SHALL set overflow.
REQ-027 overflow SHALL stay set until reset; y parity after an overflow is undefined.
REQ-028 With en=0, no new events SHALL be captured, and pending events SHALL continue to drain normally.
REQ-029 Counter wrap SHALL be handled by modulo subtraction, so dly_l <= 2^TS_W - 1 always resolves.

Reset
REQ-030 On rst=1 the block SHALL asynchronously set y=0, a_q=0, cnt=0, the queue to empty, state=IDLE, overflow=0, pending=0, busy=0, and dly_l=1.
REQ-031 Reset asserted mid-operation SHALL discard all pending events without toggling y.
REQ-032 After rst deasserts, the first edge with a=1 and en=1 SHALL count as a transition.

Structure
REQ-033 A shared package delay_pkg SHALL hold TS_W, DEPTH, the state enum {IDLE, ACTIVE}, and mode constants MODE_TRANSPORT=0 and MODE_INERTIAL=1.
REQ-034 The timestamp queue SHALL be a sub-module delay_event_fifo supporting push, pop, tail-drop, head/tail read, full and empty.
REQ-035 The scheduler FSM, counter, and compare logic SHALL reside in delay_line_scheduler.

Verification
REQ-036 Transport, dly=4: a=0 for 3 cycles, 1 for 2 cycles, then 0 -> y rises 4 cycles after the rising stamp edge, stays high 2 cycles, falls; pending peaks at 2.
REQ-037 Inertial, dly=4, same stimulus -> the 2-cycle pulse is cancelled: y stays 0, pending returns to 0, busy pulses.
REQ-038 Transport, dly=3, DEPTH=8, a toggled every cycle for 10 cycles -> pending saturates at 3 (drain rate matches), overflow stays 0; every toggle appears 3 cycles later.
REQ-039 DEPTH=8, dly=20, 9 toggles in 9 consecutive cycles -> 9th dropped, overflow=1, pending=8.
REQ-040 dly=255, event stamped at cnt=250 -> y toggles at cnt=249 after wrap; dly changed to 5 while busy -> latched value stays 255 until the queue empties.
REQ-041 rst pulsed while pending=2 -> y=0, pending=0, busy=0 immediately; no later toggles.
